// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus, with a small TX FIFO and STATUS/DIVISOR registers.
// Latency: a TXDATA store at edge k pops at edge k+1 and tx falls after k+1; each bit lasts div_q+1 cycles.
// Backpressure: none on the bus. A store to a full FIFO is dropped and sets the sticky ovf flag, unless a pop happens on the same edge.
// Ports: clk, reset (async, active-high); we/a/wd store bus; rd combinational read data (0 outside
//   the window); sel address-window hit; tx registered serial output, idle high.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Register decode
  logic [1:0] off;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_div;

  assign off       = a[3:2];
  assign sel       = (a[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = we & sel & (off == 2'd0);
  assign wr_status = we & sel & (off == 2'd1);
  assign wr_div    = we & sel & (off == 2'd2);

  // Byte-lane bits not used by any register
  logic unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:16]};

  // Registers and state
  logic [15:0]   divisor;
  logic          ovf;
  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [15:0]   baud;
  logic [15:0]   div_q;

  // TX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          baud_zero;
  logic          pop;
  logic          push_ok;
  logic          busy;
  logic [3:0]    cnt4;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign baud_zero = (baud == 16'd0);
  assign busy      = (state != IDLE);
  assign cnt4      = 4'(count);

  // A new frame starts from IDLE, or straight from the last STOP cycle so
  // back-to-back frames have no idle gap.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && baud_zero));
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok = wr_txdata && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wd[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      if (wr_div) begin
        divisor <= wd[15:0];
      end
      if (wr_txdata && !push_ok) begin
        ovf <= 1'b1;
      end else if (wr_status && wd[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Transmit FSM. div_q holds the divisor for the whole frame so that a
  // DIVISOR write only takes effect from the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      tx     <= 1'b1;
      shreg  <= 8'd0;
      bitcnt <= 3'd0;
      baud   <= 16'd0;
      div_q  <= DEFAULT_DIV;
    end else if (pop) begin
      state  <= START;
      tx     <= 1'b0;
      shreg  <= mem[rd_ptr];
      bitcnt <= 3'd0;
      div_q  <= divisor;
      baud   <= divisor;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (baud_zero) begin
            baud  <= div_q;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud <= div_q;
            if (bitcnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg  <= shreg >> 1;
              // Drive the bit that becomes shreg[0] after this shift
              tx     <= shreg[1];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (baud_zero) begin
            state <= IDLE;
            tx    <= 1'b1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Read mux
  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (off)
        2'd1:    rd = {24'd0, cnt4, ovf, empty, full, busy};
        2'd2:    rd = {16'd0, divisor};
        default: rd = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: drives the store/load bus, queues expected frames on every
// accepted TXDATA store and decodes tx with a cycle-accurate receiver that compares against the queue.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam logic [31:0] DIVA = BASE + 32'd8;
  localparam logic [31:0] RSV  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: expected byte, bit length - 1, and whether it must follow the previous frame with no gap
  typedef struct packed {
    logic        b2b;
    logic [15:0] div;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  // Receiver, sampling on the falling edge
  exp_t       cur;
  logic [9:0] frame;
  logic       rx_active   = 1'b0;
  logic [7:0] rx_byte     = 8'd0;
  int         k           = 0;
  int         mism        = 0;
  int         gap         = 0;
  int         frames_done = 0;
  int         bitlen;
  int         bi;
  int         ph;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_active = 1'b0;
      gap       = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur = sb.pop_front();
        end
        if (cur.b2b) begin
          check("b2b_gap", gap, 32'd0);
        end
        frame     = {1'b1, cur.data, 1'b0};
        rx_active = 1'b1;
        k         = 1;
        mism      = 0;
        rx_byte   = 8'd0;
      end else begin
        gap++;
      end
    end else begin
      bitlen = int'(cur.div) + 1;
      bi     = k / bitlen;
      ph     = k % bitlen;
      if (tx !== frame[bi]) mism++;
      if (bi >= 1 && bi <= 8 && ph == bitlen / 2) rx_byte[bi-1] = tx;
      k++;
      if (k == 10 * bitlen) begin
        check("frame_wave", mism, 32'd0);
        check("frame_data", {24'd0, rx_byte}, {24'd0, cur.data});
        rx_active = 1'b0;
        gap       = 0;
        frames_done++;
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic s);
    @(negedge clk);
    we = 1'b0;
    a  = addr;
    #1;
    data = rd;
    s    = sel;
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic b2b);
    sb.push_back('{b2b: b2b, div: div, data: d});
    bus_write(TXD, {24'd0, d});
  endtask

  task automatic wait_frames(input int n);
    int budget = 3000;
    while (frames_done < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("frames_done", frames_done, n);
  endtask

  logic [31:0] r;
  logic        s;

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    a     = 32'd0;
    wd    = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("tx_in_reset", {31'd0, tx}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_read(STAT, r, s);
    check("status_reset", r, 32'h04);
    check("sel_status", {31'd0, s}, 32'd1);
    bus_read(DIVA, r, s);
    check("div_reset", r, 32'd15);
    check("tx_idle", {31'd0, tx}, 32'd1);

    // Single frame, DIV=3, latency and busy
    bus_write(DIVA, 32'hABCD_0003);
    bus_read(DIVA, r, s);
    check("div_write", r, 32'd3);
    send(8'hA5, 16'd3, 1'b0);
    @(negedge clk);
    check("tx_before_start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("tx_start_bit", {31'd0, tx}, 32'd0);
    bus_read(STAT, r, s);
    check("status_busy", r, 32'h05);
    wait_frames(1);
    bus_read(STAT, r, s);
    check("status_after_frame", r, 32'h04);

    // Fill to overflow with DIV=1: lead byte pops, four fill the FIFO, fifth is dropped
    bus_write(DIVA, 32'd1);
    send(8'h3C, 16'd1, 1'b0);
    send(8'h55, 16'd1, 1'b1);
    send(8'h0F, 16'd1, 1'b1);
    send(8'hFF, 16'd1, 1'b1);
    send(8'h00, 16'd1, 1'b1);
    bus_write(TXD, 32'h81);
    bus_read(STAT, r, s);
    check("status_full_ovf", r, 32'h4B);
    wait_frames(6);
    bus_read(STAT, r, s);
    check("status_ovf_sticky", r, 32'h0C);
    bus_write(STAT, 32'h7);
    bus_read(STAT, r, s);
    check("status_wd3_zero", r, 32'h0C);
    bus_write(STAT, 32'h8);
    bus_read(STAT, r, s);
    check("status_ovf_clear", r, 32'h04);

    // DIVISOR change mid-frame applies to the next frame only
    bus_write(DIVA, 32'd3);
    send(8'h96, 16'd3, 1'b0);
    send(8'h3C, 16'd7, 1'b1);
    repeat (10) @(posedge clk);
    bus_write(DIVA, 32'd7);
    bus_read(DIVA, r, s);
    check("div_mid_frame", r, 32'd7);
    wait_frames(8);
    bus_read(STAT, r, s);
    check("status_after_div", r, 32'h04);

    // Reset during DATA bit 3 of 0xC3 (bit 3 = 0)
    bus_write(DIVA, 32'd3);
    send(8'hC3, 16'd3, 1'b0);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("tx_data_bit3", {31'd0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1 check("tx_async_reset", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(STAT, r, s);
    check("status_after_rst", r, 32'h04);
    bus_read(DIVA, r, s);
    check("div_after_rst", r, 32'd15);
    send(8'h5A, 16'd15, 1'b0);
    wait_frames(9);

    // Address decode
    bus_read(32'h60, r, s);
    check("rd_dmem", r, 32'd0);
    check("sel_dmem", {31'd0, s}, 32'd0);
    bus_read(RSV, r, s);
    check("rd_reserved", r, 32'd0);
    check("sel_reserved", {31'd0, s}, 32'd1);
    bus_read(TXD, r, s);
    check("rd_txdata", r, 32'd0);
    bus_write(32'h60, 32'h77);
    bus_read(STAT, r, s);
    check("status_no_push", r, 32'h04);
    repeat (40) @(posedge clk);
    #1 check("tx_still_idle", {31'd0, tx}, 32'd1);
    check("frames_final", frames_done, 32'd9);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
